// File: rtl/axi_write_bridge.sv
// AXI4 write-path master bridge: registered AW slice, burst-length FIFO driving WLAST, B pass-through.
// Optional protocol checking is built when AXI_WR_PROTOCOL_CHECK_EN is defined.
module axi_write_bridge #(
    parameter int AW              = 32,
    parameter int DW              = 64,
    parameter int IDW             = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     req_addr,
    input  logic [7:0]        req_len,
    input  logic [2:0]        req_size,
    input  logic [1:0]        req_burst,
    input  logic [IDW-1:0]    req_id,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DW-1:0]     wdata_in,
    input  logic [DW/8-1:0]   wstrb_in,
    input  logic              wvalid_in,
    output logic              wready_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [1:0]        rsp_resp,
    output logic [AW-1:0]     m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [IDW-1:0]    m_axi_awid,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DW-1:0]     m_axi_wdata,
    output logic [DW/8-1:0]   m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [IDW-1:0]    m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [1:0]        err
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] CNT_ONE = OW'(1);
    localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);

    logic [7:0]    len_mem [MAX_OUTSTANDING];
    logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [OW-1:0] outstanding_reg;
    logic [7:0]    beat_reg;
    logic [7:0]    head_len;
    logic          fifo_empty, fifo_full;
    logic          req_fire, w_fire, b_fire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]) &&
                        (wr_ptr_reg[PW] != rd_ptr_reg[PW]);
    assign head_len   = len_mem[rd_ptr_reg[PW-1:0]];

    assign req_ready = (!m_axi_awvalid || m_axi_awready) && !fifo_full &&
                       (outstanding_reg < MAX_CNT);
    assign req_fire  = req_valid && req_ready;

    assign m_axi_wvalid = wvalid_in && !fifo_empty;
    assign wready_out   = m_axi_wready && !fifo_empty;
    assign m_axi_wdata  = wdata_in;
    assign m_axi_wstrb  = wstrb_in;
    assign m_axi_wlast  = !fifo_empty && (beat_reg == head_len);
    assign w_fire       = m_axi_wvalid && m_axi_wready;

    assign rsp_valid    = m_axi_bvalid;
    assign m_axi_bready = rsp_ready;
    assign rsp_id       = m_axi_bid;
    assign rsp_resp     = m_axi_bresp;
    assign b_fire       = m_axi_bvalid && rsp_ready;

    always_ff @(posedge clk) begin
        if (req_fire)
            len_mem[wr_ptr_reg[PW-1:0]] <= req_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awsize  <= '0;
            m_axi_awburst <= '0;
            m_axi_awid    <= '0;
        end else if (req_fire) begin
            m_axi_awvalid <= 1'b1;
            m_axi_awaddr  <= req_addr;
            m_axi_awlen   <= req_len;
            m_axi_awsize  <= req_size;
            m_axi_awburst <= req_burst;
            m_axi_awid    <= req_id;
        end else if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            beat_reg   <= '0;
        end else begin
            if (req_fire)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (w_fire) begin
                if (m_axi_wlast) begin
                    beat_reg   <= '0;
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end else begin
                    beat_reg   <= beat_reg + 8'd1;
                end
            end
        end
    end

    // A B handshake with nothing outstanding is spurious and must not wrap the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
        end else if (req_fire && !(b_fire && outstanding_reg != '0)) begin
            outstanding_reg <= outstanding_reg + CNT_ONE;
        end else if (!req_fire && b_fire && outstanding_reg != '0) begin
            outstanding_reg <= outstanding_reg - CNT_ONE;
        end
    end

`ifdef AXI_WR_PROTOCOL_CHECK_EN
    logic [1:0]  err_reg;
    logic [16:0] burst_end;

    assign burst_end = 17'({5'd0, req_addr[11:0]}) + ((17'(req_len) + 17'd1) << req_size);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 2'b00;
        end else begin
            if (m_axi_bvalid && outstanding_reg == '0)
                err_reg[0] <= 1'b1;
            if (req_fire && req_burst == 2'b01 && burst_end > 17'd4096)
                err_reg[1] <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 2'b00;
`endif

endmodule

// File: doc/axi_write_bridge.md
# axi_write_bridge

Parametrised AXI4 write-path master bridge between a client request/data/response interface and an AXI4 master write port (AW, W, B). Registers each write-address request, queues burst lengths for up to MAX_OUTSTANDING transactions, and drives W beats with an internally generated `m_axi_wlast`. Tracks outstanding responses and returns B responses to the client. It is the configurable successor to the fixed single-transaction master/slave write composition, and sits between a client engine and the AXI interconnect.

## Interface
Parameters:
- AW, 32, address width
- DW, 64, data width (multiple of 8)
- IDW, 4, transaction ID width
- MAX_OUTSTANDING, 4, maximum accepted-but-unresponded writes (power of 2, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_addr  in  AW  burst start address
- req_len  in  8  beats minus 1
- req_size  in  3  beat size
- req_burst  in  2  burst type
- req_id  in  IDW  transaction ID
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- wdata_in  in  DW  client write data
- wstrb_in  in  DW/8  client byte strobes
- wvalid_in  in  1  client beat valid
- wready_out  out  1  client beat accepted
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts response
- rsp_id  out  IDW  response ID
- rsp_resp  out  2  response code
- m_axi_awaddr/awlen/awsize/awburst/awid  out  AW/8/3/2/IDW  AW payload
- m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_wdata  out  DW; m_axi_wstrb  out  DW/8; m_axi_wlast  out  1
- m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_bid  in  IDW; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1
- err  out  2  sticky protocol errors {[1] 4 KB crossing, [0] unexpected B}

## Operation
- AW register slice: req_ready = (!m_axi_awvalid || m_axi_awready) && !fifo_full && (outstanding < MAX_OUTSTANDING). On accept, payload is loaded into the m_axi_aw* registers, m_axi_awvalid=1, req_len is pushed to the burst FIFO, and outstanding increments.
- AW payload is held stable while m_axi_awvalid && !m_axi_awready.
- Burst FIFO: depth MAX_OUTSTANDING, stores len. W data may precede the downstream AW handshake.
- W path: m_axi_wvalid = wvalid_in && !fifo_empty; wready_out = m_axi_wready && !fifo_empty; data and strobe pass through.
- Beat counter: 8-bit, reset 0. m_axi_wlast = (beat == fifo_head_len). On a W handshake: if wlast, beat←0 and FIFO pops; otherwise beat++.
- B path: rsp_valid=m_axi_bvalid, m_axi_bready=rsp_ready, rsp_id/rsp_resp pass through. On a B handshake, outstanding decrements.
- Simultaneous request accept and B handshake: outstanding unchanged.
- Simultaneous FIFO push and pop while full is impossible because req_ready is low when full.
- Outstanding counter width: clog2(MAX_OUTSTANDING)+1. It never wraps.

## Timing
- Reset values: m_axi_awvalid=0, all AW payload=0, beat=0, FIFO empty, outstanding=0, err=0. Consequently req_ready=1, wready_out=0, m_axi_wvalid=0, m_axi_wlast=(0==undefined head) forced 0 while empty.
- Request accepted in cycle t: m_axi_awvalid is high in t+1. The FIFO is non-empty in t+1, so the first W beat can transfer in t+1.
- W and B paths are combinational: zero latency.
- Back-to-back requests accepted every cycle while awready=1 and capacity remains.
- Reset mid-operation: all queued bursts, beat count and outstanding count are discarded. The downstream slave must be reset in the same cycle.

## Configuration
- AXI_WR_PROTOCOL_CHECK_EN defined:
  - err[0] sets on m_axi_bvalid while outstanding==0.
  - err[1] sets on accept of an INCR request where (req_addr[11:0] + ((req_len+1)<<req_size)) > 4096.
  - Both bits are sticky until rst.
- Not defined: err is tied to 0 and no check logic is built.

## Test plan
- Single beat (len=0, addr=0x100, id=3): wlast=1 on the only beat. B (id 3, OKAY) gives rsp_valid=1, rsp_id=3, rsp_resp=0.
- 4-beat INCR (len=3): wlast is low for beats 0–2 and high on beat 3. FIFO is empty afterwards.
- MAX_OUTSTANDING=4, five requests with no B: req_ready drops after the 4th accept. One B handshake re-raises req_ready the next cycle.
- m_axi_awready held low for 3 cycles: awaddr/awlen stay stable and req_ready=0. Accept completes on the awready cycle.
- Request accept and B handshake in the same cycle with outstanding=2: outstanding remains 2.
- With AXI_WR_PROTOCOL_CHECK_EN: spurious bvalid after reset gives err=2'b01. Request addr=0xFF0, len=3, size=3 gives err[1]=1. Without the macro, err stays 0.
